mouse_cursor_sequencer: RTL and testbench
=========================================

Name: mouse_cursor_sequencer

Overview:
- Sequences the 11-row x 8-pixel cursor bitmap ROM (`mouse_painter`) for the video pipeline.
- Per scanline it decides whether the cursor covers that line, drives the ROM row address and captures the returned row code.
- Serialises the row code into a per-pixel cursor mask aligned to the latched mouse position.
- Sits between the VGA timing generator and the pixel mux, which overlays `cursor_pixel` on the frame colour.

Parameters:
- COORD_W, 11, width of hcount/vcount/mouse coordinates.
- CURSOR_W, 8, bitmap width in pixels; equals ROM line_code width.
- CURSOR_H, 11, number of valid bitmap rows (ROM rows 0..10).
- BLINK_FRAMES, 30, frames per blink half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel strobe; one pixel advances per pix_en cycle.
- line_start  in  1  single-cycle pulse at the start of each scanline, before hcount reaches 0.
- frame_start  in  1  single-cycle pulse at the start of each frame (vertical blank).
- hcount  in  COORD_W  current pixel column.
- vcount  in  COORD_W  current scanline.
- mouse_x  in  COORD_W  new cursor column.
- mouse_y  in  COORD_W  new cursor row.
- mouse_valid  in  1  single-cycle update strobe for mouse_x/mouse_y.
- rom_line_number  out  5  row address to the bitmap ROM.
- rom_line_code  in  CURSOR_W  combinational ROM data.
- cursor_pixel  out  1  cursor mask for the current pixel.
- cursor_active  out  1  high while the cursor row is being serialised.

Behaviour:
- Reset values: rom_line_number=0, cursor_pixel=0, cursor_active=0, FSM=IDLE, all position registers=0, row buffer=0.
- Position registers:
  - mouse_valid loads pend_x/pend_y.
  - frame_start copies pend into cur_x/cur_y, so the position never changes mid-frame.
  - If mouse_valid and frame_start occur in the same cycle, the new mouse_x/y go directly into both pend and cur.
- FSM IDLE: on line_start compute row = vcount - cur_y (COORD_W-bit modulo subtraction).
  - If row < CURSOR_H (unsigned): drive rom_line_number = row[4:0] and go to FETCH.
  - Otherwise stay in IDLE.
  - vcount < cur_y wraps to a large value and is rejected.
- FSM FETCH: one cycle; capture rom_line_code into the row buffer and go to ARMED.
- FSM ARMED: on a cycle where pix_en=1 and hcount==cur_x, go to SHIFT.
  - That same pixel outputs buffer bit 0; shift count = 1.
- FSM SHIFT: each pix_en outputs the next buffer bit (bit i maps to column cur_x+i).
  - After CURSOR_W pixels, return to IDLE; cursor_pixel=0 from then on.
- Output timing:
  - cursor_pixel and cursor_active are registered and valid one clk after the pix_en cycle they describe.
  - cursor_active=1 exactly for SHIFT pixels; cursor_pixel=0 whenever cursor_active=0.
- Simultaneous events and clipping:
  - line_start in ARMED or SHIFT aborts the current row: outputs go to 0 and IDLE evaluation happens in the same cycle. This is how right-edge clipping works.
  - frame_start in any state forces IDLE and clears the outputs; it takes priority over line_start.
- pix_en=0 freezes SHIFT and ARMED; no bits are lost.
- rom_line_number holds its last value outside FETCH.
- Reset mid-operation returns immediately to the reset values.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- When defined:
  - A frame counter (counting frame_start) toggles a visible flag every BLINK_FRAMES frames; reset value is visible=1.
  - When visible=0, cursor_pixel is forced to 0. cursor_active and the FSM run unchanged.
- When undefined: no counter exists and the cursor is always visible.

Decomposition:
- Shared package `video_pkg` holds:
  - the FSM state typedef (IDLE, FETCH, ARMED, SHIFT);
  - constants CURSOR_W and CURSOR_H;
  - the coordinate typedef (COORD_W bits).
- One sub-module is natural: `cursor_row_shifter`, containing the row buffer, shift counter and pixel output, with load/shift/abort inputs.
- The FSM and position registers stay in the top module.

Test Plan:
- Reset then mouse_valid(100,50) then frame_start; line_start at vcount=50 -> rom_line_number=0 in FETCH; at hcount=100 with pix_en, cursor_pixel=1 for 1 pixel, then 0 for 7 (code 8'h01).
- vcount=57, cur at (100,50) -> row 7, code 8'hFF, cursor_pixel=1 for hcount 100..107, cursor_active high for exactly 8 pix_en.
- vcount=49 and vcount=61 with cur_y=50 -> FSM stays IDLE, cursor_pixel never asserts; vcount=60 -> row 10, code 8'h01.
- cur_x=636, line_start 3 pixels after hcount=636 -> shift aborted, outputs 0, next row fetched correctly.
- mouse_valid(200,80) mid-frame -> rows still drawn at the old position until frame_start; mouse_valid coincident with frame_start -> new position used that frame.
- CURSOR_BLINK_EN with BLINK_FRAMES=2 -> mask visible in frames 0-1, suppressed in frames 2-3, visible in frames 4-5; cursor_active identical in every frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-pipeline types: cursor geometry, coordinate width and the
// cursor sequencer state encoding.
package video_pkg;

  localparam int COORD_W  = 11;
  localparam int CURSOR_W = 8;
  localparam int CURSOR_H = 11;
  localparam int CNT_W    = $clog2(CURSOR_W + 1);

  typedef logic [COORD_W-1:0] coord_t;

  typedef logic [1:0] cursor_state_t;
  localparam cursor_state_t ST_IDLE  = 2'd0;
  localparam cursor_state_t ST_FETCH = 2'd1;
  localparam cursor_state_t ST_ARMED = 2'd2;
  localparam cursor_state_t ST_SHIFT = 2'd3;

endpackage

// File: rtl/cursor_row_shifter.sv
// Holds one captured cursor row and serialises it LSB-first, one bit per
// start/shift strobe, into registered pixel/active outputs.
module cursor_row_shifter
  import video_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_en,
  input  logic                load,
  input  logic                start,
  input  logic                shift,
  input  logic                abort,
  input  logic [CURSOR_W-1:0] row_code,
  output logic                last,
  output logic                pixel,
  output logic                active
);

  logic [CURSOR_W-1:0] row_buf;
  logic [CNT_W-1:0]    remain;

  // remain counts bits still owed after the one currently on the output
  assign last = (remain == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_buf <= '0;
      remain  <= '0;
      pixel   <= 1'b0;
      active  <= 1'b0;
    end else begin
      if (load)
        row_buf <= row_code;
      if (abort) begin
        pixel  <= 1'b0;
        active <= 1'b0;
        remain <= '0;
      end else if (start || shift) begin
        pixel   <= row_buf[0];
        active  <= 1'b1;
        row_buf <= row_buf >> 1;
        remain  <= start ? CNT_W'(CURSOR_W - 1) : remain - CNT_W'(1);
      end else if (pix_en) begin
        pixel  <= 1'b0;
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mouse_cursor_sequencer.sv
// Per-scanline cursor ROM sequencer producing a registered per-pixel cursor mask.
// Optional blinking is enabled by defining CURSOR_BLINK_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no row in flight; evaluates vcount on line_start
// ST_FETCH | ROM address driven, row code captured this cycle
// ST_ARMED | waiting for pix_en with hcount == cur_x
// ST_SHIFT | serialising the remaining row bits, one per pix_en
module mouse_cursor_sequencer
  import video_pkg::*;
  #(parameter int BLINK_FRAMES = 30)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_en,
  input  logic                line_start,
  input  logic                frame_start,
  input  logic [COORD_W-1:0]  hcount,
  input  logic [COORD_W-1:0]  vcount,
  input  logic [COORD_W-1:0]  mouse_x,
  input  logic [COORD_W-1:0]  mouse_y,
  input  logic                mouse_valid,
  output logic [4:0]          rom_line_number,
  input  logic [CURSOR_W-1:0] rom_line_code,
  output logic                cursor_pixel,
  output logic                cursor_active
);

  coord_t        pend_x, pend_y, cur_x, cur_y;
  coord_t        row;
  cursor_state_t state;
  logic          row_hit, x_hit, sh_start, sh_step, sh_last, pix_raw;

  // rows above the cursor wrap to large values and fail the compare
  assign row      = vcount - cur_y;
  assign row_hit  = row < coord_t'(CURSOR_H);
  assign x_hit    = pix_en && (hcount == cur_x);
  assign sh_start = (state == ST_ARMED) && x_hit && !line_start && !frame_start;
  assign sh_step  = (state == ST_SHIFT) && pix_en && !line_start && !frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x <= '0;
      pend_y <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else begin
      if (mouse_valid) begin
        pend_x <= mouse_x;
        pend_y <= mouse_y;
      end
      if (frame_start) begin
        cur_x <= mouse_valid ? mouse_x : pend_x;
        cur_y <= mouse_valid ? mouse_y : pend_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rom_line_number <= '0;
    end else if (frame_start) begin
      state <= ST_IDLE;
    end else if (line_start && (state != ST_FETCH)) begin
      if (row_hit) begin
        state           <= ST_FETCH;
        rom_line_number <= row[4:0];
      end else begin
        state <= ST_IDLE;
      end
    end else begin
      case (state)
        ST_FETCH: state <= ST_ARMED;
        ST_ARMED: if (x_hit) state <= ST_SHIFT;
        ST_SHIFT: if (pix_en && sh_last) state <= ST_IDLE;
        default: ;
      endcase
    end
  end

  cursor_row_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_en   (pix_en),
    .load     (state == ST_FETCH),
    .start    (sh_start),
    .shift    (sh_step),
    .abort    (frame_start || line_start),
    .row_code (rom_line_code),
    .last     (sh_last),
    .pixel    (pix_raw),
    .active   (cursor_active)
  );

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_CW = $clog2(BLINK_FRAMES + 1);

  logic [BLINK_CW-1:0] blink_cnt;
  logic                visible;

  // starts one above the reload value so the first toggle lands on frame BLINK_FRAMES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= BLINK_CW'(BLINK_FRAMES);
      visible   <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == '0) begin
        visible   <= ~visible;
        blink_cnt <= BLINK_CW'(BLINK_FRAMES - 1);
      end else begin
        blink_cnt <= blink_cnt - BLINK_CW'(1);
      end
    end
  end

  assign cursor_pixel = pix_raw & visible;
`else
  assign cursor_pixel = pix_raw;
`endif

endmodule

// File: tb/tb_mouse_cursor_sequencer.sv
// Directed bench for mouse_cursor_sequencer: scanline vector table plus
// hand sequences for clipping, position latching, priority, reset and blink.
module tb_mouse_cursor_sequencer;

  logic        clk, rst_n, pix_en, line_start, frame_start, mouse_valid;
  logic [10:0] hcount, vcount, mouse_x, mouse_y;
  logic [4:0]  rom_line_number;
  logic [7:0]  rom_line_code;
  logic        cursor_pixel, cursor_active;

  logic [7:0]  rom_tbl [32];
  int          n_tests, n_fail;
  int          last_rom;

  typedef struct {
    string       name;
    logic [10:0] vline;
    logic [10:0] cx;
    logic [10:0] h_first;
    int          n_pix;
    int          exp_row;
    bit          gap;
  } vec_t;

  vec_t vecs [8];

  assign rom_line_code = rom_tbl[rom_line_number];

  mouse_cursor_sequencer #(.BLINK_FRAMES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_en          (pix_en),
    .line_start      (line_start),
    .frame_start     (frame_start),
    .hcount          (hcount),
    .vcount          (vcount),
    .mouse_x         (mouse_x),
    .mouse_y         (mouse_y),
    .mouse_valid     (mouse_valid),
    .rom_line_number (rom_line_number),
    .rom_line_code   (rom_line_code),
    .cursor_pixel    (cursor_pixel),
    .cursor_active   (cursor_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int vline, input int cx,
                              input int h_first, input int n_pix, input int exp_row,
                              input bit gap);
    vec_t v;
    v.name    = name;
    v.vline   = 11'(vline);
    v.cx      = 11'(cx);
    v.h_first = 11'(h_first);
    v.n_pix   = n_pix;
    v.exp_row = exp_row;
    v.gap     = gap;
    return v;
  endfunction

  function automatic bit vis_of(input int f);
`ifdef CURSOR_BLINK_EN
    return ((f / 2) % 2) == 0;
`else
    return (f >= 0);
`endif
  endfunction

  task automatic mouse_upd(input int x, input int y, input bit with_frame);
    mouse_x     = 11'(x);
    mouse_y     = 11'(y);
    mouse_valid = 1'b1;
    frame_start = with_frame;
    tick();
    mouse_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One scanline: line_start, FETCH, then n_pix pixel strobes from h_first.
  task automatic run_line(input logic [10:0] vline, input logic [10:0] cx,
                          input logic [10:0] h_first, input int n_pix, input int exp_row,
                          input bit gap, input bit fs, input bit vis, input string name);
    logic [7:0] got_mask, exp_mask, code;
    int got_act, exp_act, stray, hi;
    got_mask = '0;
    exp_mask = '0;
    got_act  = 0;
    exp_act  = 0;
    stray    = 0;
    code     = (exp_row >= 0) ? rom_tbl[exp_row] : 8'h00;
    pix_en      = 1'b0;
    vcount      = vline;
    line_start  = 1'b1;
    frame_start = fs;
    tick();
    line_start  = 1'b0;
    frame_start = 1'b0;
    check({name, "/ls_clear"}, {30'd0, cursor_active, cursor_pixel}, 32'd0);
    check({name, "/rom_addr"}, {27'd0, rom_line_number},
          32'((exp_row >= 0) ? exp_row : last_rom));
    if (exp_row >= 0) last_rom = exp_row;
    tick();
    for (int i = 0; i < n_pix; i++) begin
      hcount = h_first + 11'(i);
      if (gap) begin
        pix_en = 1'b0;
        tick();
      end
      pix_en = 1'b1;
      tick();
      hi = int'(hcount) - int'(cx);
      if (hi >= 0 && hi < 8) begin
        got_mask[hi] = cursor_pixel;
        if (cursor_active) got_act++;
        if (exp_row >= 0) begin
          exp_mask[hi] = code[hi] & vis;
          exp_act++;
        end
      end else if (cursor_pixel || cursor_active) begin
        stray++;
      end
    end
    pix_en = 1'b0;
    check({name, "/stray_act_mask"}, {8'd0, 8'(stray), 8'(got_act), got_mask},
          {8'd0, 8'd0, 8'(exp_act), exp_mask});
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    last_rom = 0;
    for (int i = 0; i < 32; i++) rom_tbl[i] = 8'h00;
    rom_tbl[0] = 8'h01; rom_tbl[1] = 8'h03; rom_tbl[2]  = 8'h07; rom_tbl[3] = 8'h0F;
    rom_tbl[4] = 8'h1F; rom_tbl[5] = 8'h3F; rom_tbl[6]  = 8'h7F; rom_tbl[7] = 8'hFF;
    rom_tbl[8] = 8'h3C; rom_tbl[9] = 8'h66; rom_tbl[10] = 8'h01;

    vecs[0] = mk("row0_v50",        50,  100, 90, 26,  0, 1'b0);
    vecs[1] = mk("row7_v57",        57,  100, 90, 26,  7, 1'b0);
    vecs[2] = mk("above_v49",       49,  100, 90, 26, -1, 1'b0);
    vecs[3] = mk("below_v61",       61,  100, 90, 26, -1, 1'b0);
    vecs[4] = mk("last_row_v60",    60,  100, 90, 26, 10, 1'b0);
    vecs[5] = mk("row3_pix_gaps",   53,  100, 95, 16,  3, 1'b1);
    vecs[6] = mk("far_v1000",       1000, 100, 90, 26, -1, 1'b0);
    vecs[7] = mk("row5_start_at_x", 55,  100, 100, 12, 5, 1'b0);

    rst_n = 1'b0; pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    mouse_valid = 1'b0; hcount = '0; vcount = '0; mouse_x = '0; mouse_y = '0;
    repeat (3) tick();
    check("reset/rom_line_number", {27'd0, rom_line_number}, 32'd0);
    check("reset/cursor_pixel", {31'd0, cursor_pixel}, 32'd0);
    check("reset/cursor_active", {31'd0, cursor_active}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    mouse_upd(100, 50, 1'b0);
    frame_pulse();
    foreach (vecs[k])
      run_line(vecs[k].vline, vecs[k].cx, vecs[k].h_first, vecs[k].n_pix,
               vecs[k].exp_row, vecs[k].gap, 1'b0, 1'b1, vecs[k].name);

    // Mid-frame update must not move the cursor until frame_start.
    mouse_upd(636, 50, 1'b0);
    run_line(50, 100, 90, 26, 0, 1'b0, 1'b0, 1'b1, "midframe_old_pos");
    frame_pulse();

    // Right-edge clip: line_start lands 3 pixels into the row.
    run_line(52, 636, 630, 9, 2, 1'b0, 1'b0, 1'b1, "clip_partial");
    run_line(53, 636, 630, 16, 3, 1'b0, 1'b0, 1'b1, "clip_next_row");

    // Update coincident with frame_start takes effect this frame.
    mouse_upd(300, 20, 1'b1);
    run_line(22, 300, 295, 14, 2, 1'b0, 1'b0, 1'b1, "coincident_pos");

    // frame_start beats line_start: no fetch, address holds.
    run_line(21, 300, 295, 14, -1, 1'b0, 1'b1, 1'b1, "fs_over_ls");

    // Asynchronous reset in the middle of a row.
    vcount = 11'd27; line_start = 1'b1; tick(); line_start = 1'b0; tick();
    hcount = 11'd300; pix_en = 1'b1; tick();
    hcount = 11'd301; tick();
    pix_en = 1'b0;
    check("pre_reset/active_pixel", {30'd0, cursor_active, cursor_pixel}, 32'd3);
    rst_n = 1'b0;
    #2;
    check("mid_reset/rom_active_pixel",
          {25'd0, rom_line_number, cursor_active, cursor_pixel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rom = 0;
    tick();

    // Frame sequence from reset; mask gated by blink, active unaffected.
    mouse_upd(100, 50, 1'b1);
    for (int f = 0; f < 6; f++) begin
      if (f > 0) frame_pulse();
      run_line(57, 100, 96, 14, 7, 1'b0, 1'b0, vis_of(f), $sformatf("frame%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
